// File: rtl/nand4_exerciser.sv
// Stimulus/response checker for a 4-input NAND gate: walks all 16 input
// vectors on start, compares X_in against ~&vec and reports errors.
module nand4_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int WAIT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       X_in,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);

  // start is a level request, not a valid/ready pair: it is accepted on any
  // rising edge where the FSM is in IDLE and dropped otherwise (never queued).

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYCLES - 1);

  logic [1:0]        state;
  logic [3:0]        vec;
  logic [3:0]        drive;
  logic [WAIT_W-1:0] wait_cnt;
  logic              expected;
  logic              mismatch;

  // Gate pins come straight from a register so they never glitch.
  assign {A, B, C, D} = drive;

  assign expected = ~&vec;
  assign mismatch = (X_in != expected);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vec        <= 4'd0;
      drive      <= 4'd0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 5'd0;
      fail_valid <= 1'b0;
      fail_vec   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            vec        <= 4'd0;
            drive      <= 4'd0;
            wait_cnt   <= '0;
            err_count  <= 5'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 4'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= S_SAMPLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 5'd1;
            if (!fail_valid) begin
              fail_vec   <= vec;
              fail_valid <= 1'b1;
            end
          end
          if (vec == 4'd15) begin
            state <= S_DONE;
          end else begin
            // drive tracks vec so the next vector appears on the pins now
            vec      <= vec + 4'd1;
            drive    <= vec + 4'd1;
            wait_cnt <= '0;
            state    <= S_SETTLE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == 5'd0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand4_exerciser.sv
// Directed bench for nand4_exerciser: two instances (SETTLE_CYCLES 2 and 1)
// each driven by a configurable gate model on X_in.
module tb_nand4_exerciser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   mode0 = 0;
  int   mode1 = 0;
  int   sel = 0;

  logic       a0, b0, c0, d0, busy0, done0, pass0, fv0, x0;
  logic [4:0] err0;
  logic [3:0] fvec0;
  logic       a1, b1, c1, d1, busy1, done1, pass1, fv1, x1;
  logic [4:0] err1;
  logic [3:0] fvec1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Gate models: 0 good NAND, 1 stuck-at-1, 2 stuck-at-0, 3 NAND ignoring D.
  function automatic logic gate_model(input int m, input logic [3:0] v);
    logic r;
    r = ~&v;
    case (m)
      1: r = 1'b1;
      2: r = 1'b0;
      3: r = ~&v[3:1];
      default: r = ~&v;
    endcase
    return r;
  endfunction

  always_comb x0 = gate_model(mode0, {a0, b0, c0, d0});
  always_comb x1 = gate_model(mode1, {a1, b1, c1, d1});

  nand4_exerciser #(.SETTLE_CYCLES(2), .WAIT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .X_in(x0),
    .A(a0), .B(b0), .C(c0), .D(d0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .fail_vec(fvec0)
  );

  nand4_exerciser #(.SETTLE_CYCLES(1), .WAIT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .X_in(x1),
    .A(a1), .B(b1), .C(c1), .D(d1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1)
  );

  // Selected-instance view so one run task serves both DUTs.
  logic [3:0] s_abcd, s_fvec;
  logic [4:0] s_err;
  logic       s_busy, s_done, s_pass, s_fv;
  always_comb begin
    s_abcd = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};
    s_fvec = sel ? fvec1 : fvec0;
    s_err  = sel ? err1 : err0;
    s_busy = sel ? busy1 : busy0;
    s_done = sel ? done1 : done0;
    s_pass = sel ? pass1 : pass0;
    s_fv   = sel ? fv1 : fv0;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v;
    else start1 = v;
  endtask

  // One run on the selected DUT. repulse_k: edge offset after E0 at which a
  // one-cycle start pulse is injected mid-run (0 = none).
  task automatic run(input int settle, input int chk_seq, input int repulse_k,
                     input int exp_err, input int exp_fv, input int exp_fvec,
                     input int exp_pass);
    int total;
    int lat;
    int exp_v;
    total = 16 * (settle + 1) + 1;
    lat = 0;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    check("busy_after_start", s_busy, 1);
    check("done_cleared", s_done, 0);
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (repulse_k != 0 && k == repulse_k) set_start(1'b1);
      if (repulse_k != 0 && k == repulse_k + 1) set_start(1'b0);
      if (chk_seq != 0 && k < total) begin
        exp_v = k / (settle + 1);
        if (exp_v > 15) exp_v = 15;
        check($sformatf("abcd_k%0d", k), s_abcd, exp_v);
      end
      if (s_done) lat = k;
    end
    check("done_latency", lat, total);
    check("busy_end", s_busy, 0);
    check("pass", s_pass, exp_pass);
    check("err_count", s_err, exp_err);
    check("fail_valid", s_fv, exp_fv);
    check("fail_vec", s_fvec, exp_fvec);
    @(posedge clk);
    #1;
    check("done_sticky", s_done, 1);
    check("err_stable", s_err, exp_err);
  endtask

  initial begin
    // Power-on reset.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_abcd", {a0, b0, c0, d0}, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_err", err0, 0);
    rst_n = 1'b1;

    // Good gate: full sequence, latency 49, pass.
    sel = 0; mode0 = 0;
    run(2, 1, 0, 0, 0, 0, 1);
    // Stuck-at-1: only 1111 mismatches.
    mode0 = 1;
    run(2, 0, 0, 1, 1, 15, 0);
    // Stuck-at-0: 15 mismatches, first at 0000.
    mode0 = 2;
    run(2, 0, 0, 15, 1, 0, 0);
    // D ignored: only 1110 mismatches.
    mode0 = 3;
    run(2, 0, 0, 1, 1, 14, 0);
    // Start re-pulse while vec=5 is ignored; latency unchanged.
    mode0 = 0;
    run(2, 0, 15, 0, 0, 0, 1);

    // Reset mid-run at vec=7.
    mode0 = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    check("mid_vec7", {a0, b0, c0, d0}, 7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_abcd", {a0, b0, c0, d0}, 0);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_done", done0, 0);
    check("mid_rst_pass", pass0, 0);
    check("mid_rst_err", err0, 0);
    check("mid_rst_fv", fv0, 0);
    check("mid_rst_fvec", fvec0, 0);
    @(posedge clk);
    #1;
    check("mid_rst_idle", busy0, 0);
    mode0 = 0;
    run(2, 0, 0, 0, 0, 0, 1);

    // SETTLE_CYCLES=1 instance: sequence and 33-edge latency, then re-pulse.
    sel = 1; mode1 = 0;
    run(1, 1, 0, 0, 0, 0, 1);
    mode1 = 3;
    run(1, 0, 11, 1, 1, 14, 0);

    // start held high: done visible for exactly one cycle, then relaunch.
    mode1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 100 && seen == 0; k++) begin
        @(posedge clk);
        #1;
        if (done1) seen = 1;
      end
      check("held_done_seen", seen, 1);
      check("held_pass", pass1, 1);
      @(posedge clk);
      #1;
      check("held_done_one_cycle", done1, 0);
      check("held_relaunch_busy", busy1, 1);
    end
    start1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
